// File: rtl/calc1_core.sv
// calc1_core: four-port 32-bit calculator. Two shared execution units (add/sub,
// shift) serve the ports through fixed-priority arbitration, lowest port first.
module calc1_core (
   input  logic        c_clk,
   input  logic [1:7]  reset,
   input  logic [0:3]  req1_cmd_in,
   input  logic [0:31] req1_data_in,
   input  logic [0:3]  req2_cmd_in,
   input  logic [0:31] req2_data_in,
   input  logic [0:3]  req3_cmd_in,
   input  logic [0:31] req3_data_in,
   input  logic [0:3]  req4_cmd_in,
   input  logic [0:31] req4_data_in,
   output logic [0:31] out_data1,
   output logic [0:1]  out_resp1,
   output logic [0:31] out_data2,
   output logic [0:1]  out_resp2,
   output logic [0:31] out_data3,
   output logic [0:1]  out_resp3,
   output logic [0:31] out_data4,
   output logic [0:1]  out_resp4
);

   localparam logic [3:0] CMD_ADD = 4'd1;
   localparam logic [3:0] CMD_SUB = 4'd2;
   localparam logic [3:0] CMD_SHL = 4'd5;
   localparam logic [3:0] CMD_SHR = 4'd6;
   localparam logic [1:0] RESP_OK  = 2'd1;
   localparam logic [1:0] RESP_ERR = 2'd2;

   typedef enum logic [2:0] {S_IDLE, S_OP2, S_PEND, S_EXEC, S_RESP} port_state_e;

   logic        rst;
   logic [3:0]  cmd_in  [4];
   logic [31:0] data_in [4];

   port_state_e state_q [4];
   port_state_e state_d [4];
   logic [3:0]  cmd_q   [4];
   logic [31:0] op1_q   [4];
   logic [31:0] op2_q   [4];
   logic [31:0] data_q  [4];
   logic [1:0]  resp_q  [4];

   logic [3:0]  as_req, sh_req, bad_req;
   logic        as_any, sh_any;
   logic [1:0]  as_idx, sh_idx;
   logic        as_vld_q, sh_vld_q;
   logic [1:0]  as_sel_q, sh_sel_q;

   logic [31:0] as_a, as_b, as_res;
   logic [32:0] as_sum;
   logic [1:0]  as_resp;
   logic [31:0] sh_a, sh_res;
   logic [4:0]  sh_amt;

   assign rst = |reset;

   assign cmd_in[0]  = req1_cmd_in;
   assign cmd_in[1]  = req2_cmd_in;
   assign cmd_in[2]  = req3_cmd_in;
   assign cmd_in[3]  = req4_cmd_in;
   assign data_in[0] = req1_data_in;
   assign data_in[1] = req2_data_in;
   assign data_in[2] = req3_data_in;
   assign data_in[3] = req4_data_in;

   assign out_data1 = data_q[0];
   assign out_resp1 = resp_q[0];
   assign out_data2 = data_q[1];
   assign out_resp2 = resp_q[1];
   assign out_data3 = data_q[2];
   assign out_resp3 = resp_q[2];
   assign out_data4 = data_q[3];
   assign out_resp4 = resp_q[3];

   // Sort pending ports by the unit they need; anything else is an invalid command.
   always_comb begin : classify
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      as_req  = '0;
      sh_req  = '0;
      bad_req = '0;
      for (int i = 0; i < 4; i++) begin
         if (state_q[i] == S_PEND) begin
            case (cmd_q[i])
               CMD_ADD, CMD_SUB: as_req[i]  = 1'b1;
               CMD_SHL, CMD_SHR: sh_req[i]  = 1'b1;
               default:          bad_req[i] = 1'b1;
            endcase
         end
      end
   end

   // Descending scan so the lowest requesting port is the last to overwrite the winner.
   always_comb begin : arbitrate
      as_idx = '0;
      sh_idx = '0;
      for (int i = 3; i >= 0; i--) begin
         if (as_req[i]) as_idx = 2'(i);
         if (sh_req[i]) sh_idx = 2'(i);
      end
   end

   assign as_any = |as_req;
   assign sh_any = |sh_req;

   always_comb begin : next_state
      for (int i = 0; i < 4; i++) begin
         state_d[i] = state_q[i];
         case (state_q[i])
            S_IDLE: if (cmd_in[i] != '0) state_d[i] = S_OP2;
            S_OP2:  state_d[i] = S_PEND;
            S_PEND: begin
               if (bad_req[i])
                  state_d[i] = S_RESP;
               else if ((as_any && as_idx == 2'(i)) || (sh_any && sh_idx == 2'(i)))
                  state_d[i] = S_EXEC;
            end
            S_EXEC: state_d[i] = S_RESP;
            S_RESP: state_d[i] = (cmd_in[i] != '0) ? S_OP2 : S_IDLE;
            default: state_d[i] = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge c_clk) begin : state_reg
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      for (int i = 0; i < 4; i++)
         state_q[i] <= rst ? S_IDLE : state_d[i];
   end

   always_comb begin : addsub_unit
      as_a    = op1_q[as_sel_q];
      as_b    = op2_q[as_sel_q];
      as_sum  = {1'b0, as_a} + {1'b0, as_b};
      as_res  = as_sum[31:0];
      as_resp = RESP_OK;
      if (cmd_q[as_sel_q] == CMD_SUB) begin
         if (as_b > as_a) begin
            as_res  = '0;
            as_resp = RESP_ERR;
         end else begin
            as_res  = as_a - as_b;
         end
      end else if (as_sum[32]) begin
         as_res  = '0;
         as_resp = RESP_ERR;
      end
   end

   always_comb begin : shift_unit
      sh_a   = op1_q[sh_sel_q];
      sh_amt = op2_q[sh_sel_q][4:0];
      sh_res = (cmd_q[sh_sel_q] == CMD_SHL) ? (sh_a << sh_amt) : (sh_a >> sh_amt);
   end

   // Outputs default to zero every cycle, so a response is visible for exactly one cycle.
   always_ff @(posedge c_clk) begin : datapath
      if (rst) begin
         // NOTE: operand/command registers are not reset; they are only read once the port FSM qualifies them.
         as_vld_q <= 1'b0;
         sh_vld_q <= 1'b0;
         as_sel_q <= '0;
         sh_sel_q <= '0;
         for (int i = 0; i < 4; i++) begin
            data_q[i] <= '0;
            resp_q[i] <= '0;
         end
      end else begin
         as_vld_q <= as_any;
         sh_vld_q <= sh_any;
         as_sel_q <= as_idx;
         sh_sel_q <= sh_idx;
         for (int i = 0; i < 4; i++) begin
            data_q[i] <= '0;
            resp_q[i] <= '0;
            if ((state_q[i] == S_IDLE || state_q[i] == S_RESP) && cmd_in[i] != '0) begin
               cmd_q[i] <= cmd_in[i];
               op1_q[i] <= data_in[i];
            end
            if (state_q[i] == S_OP2) op2_q[i] <= data_in[i];
            if (bad_req[i]) resp_q[i] <= RESP_ERR;
         end
         if (as_vld_q) begin
            data_q[as_sel_q] <= as_res;
            resp_q[as_sel_q] <= as_resp;
         end
         if (sh_vld_q) begin
            data_q[sh_sel_q] <= sh_res;
            resp_q[sh_sel_q] <= RESP_OK;
         end
      end
   end

endmodule

// File: tb/tb_calc1_core.sv
// tb_calc1_core: directed vectors with a per-port scoreboard of expected
// response code, result and arrival cycle; a negedge monitor pops and compares.
module tb_calc1_core;

   typedef struct packed {
      logic [1:0]  resp;
      logic [31:0] data;
      logic [31:0] cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic [1:7]  rst;
   logic [3:0]  cmd_in  [4];
   logic [31:0] data_in [4];
   logic [31:0] data_o  [4];
   logic [1:0]  resp_o  [4];

   logic [31:0] op2_hold [4];
   bit          stage    [4];
   exp_t        sb [4][$];
   exp_t        mon_e;
   int          cyc    = 0;
   int          checks = 0;
   int          errors = 0;
   bit          mon_en = 1'b0;

   calc1_core dut (
      .c_clk        (clk),
      .reset        (rst),
      .req1_cmd_in  (cmd_in[0]),
      .req1_data_in (data_in[0]),
      .req2_cmd_in  (cmd_in[1]),
      .req2_data_in (data_in[1]),
      .req3_cmd_in  (cmd_in[2]),
      .req3_data_in (data_in[2]),
      .req4_cmd_in  (cmd_in[3]),
      .req4_data_in (data_in[3]),
      .out_data1    (data_o[0]),
      .out_resp1    (resp_o[0]),
      .out_data2    (data_o[1]),
      .out_resp2    (resp_o[1]),
      .out_data3    (data_o[2]),
      .out_resp3    (resp_o[2]),
      .out_data4    (data_o[3]),
      .out_resp4    (resp_o[3])
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   // Monitor: any non-zero response must match the head of that port's queue.
   always @(negedge clk) begin
      if (mon_en) begin
         for (int p = 0; p < 4; p++) begin
            if (resp_o[p] !== 2'd0) begin
               if (sb[p].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL port%0d_unexpected got resp %0d data %h at cycle %0d want no response",
                           p + 1, resp_o[p], data_o[p], cyc);
               end else begin
                  mon_e = sb[p].pop_front();
                  check($sformatf("port%0d_resp", p + 1), 32'(resp_o[p]), 32'(mon_e.resp));
                  check($sformatf("port%0d_data", p + 1), data_o[p], mon_e.data);
                  check($sformatf("port%0d_cycle", p + 1), 32'(cyc), mon_e.cyc);
               end
            end else if (data_o[p] !== 32'd0) begin
               check($sformatf("port%0d_idle_data", p + 1), data_o[p], 32'd0);
            end
         end
      end
   end

   task automatic start(input int p, input logic [3:0] cmd, input logic [31:0] op1,
                        input logic [31:0] op2, input logic [1:0] r, input logic [31:0] d,
                        input int lat, input bit want);
      exp_t e;
      cmd_in[p]   = cmd;
      data_in[p]  = op1;
      op2_hold[p] = op2;
      stage[p]    = 1'b1;
      if (want) begin
         e.resp = r;
         e.data = d;
         e.cyc  = 32'(cyc + lat);
         sb[p].push_back(e);
      end
   endtask

   task automatic step();
      @(negedge clk);
      for (int p = 0; p < 4; p++) begin
         cmd_in[p]  = '0;
         data_in[p] = stage[p] ? op2_hold[p] : 32'd0;
         stage[p]   = 1'b0;
      end
   endtask

   function automatic int pending();
      int n = 0;
      for (int p = 0; p < 4; p++) n += sb[p].size();
      return n;
   endfunction

   task automatic drain(input string name);
      int n = 0;
      while (pending() != 0 && n < 20) begin
         step();
         n++;
      end
      check({name, "_drained"}, 32'(pending()), 32'd0);
      for (int p = 0; p < 4; p++) sb[p].delete();
      repeat (2) step();
   endtask

   task automatic check_all_zero(input string name);
      for (int p = 0; p < 4; p++) begin
         check($sformatf("%s_resp%0d", name, p + 1), 32'(resp_o[p]), 32'd0);
         check($sformatf("%s_data%0d", name, p + 1), data_o[p], 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst    = '0;
      rst[1] = 1'b1;
      for (int p = 0; p < 4; p++) begin
         cmd_in[p]  = '0;
         data_in[p] = '0;
         stage[p]   = 1'b0;
      end
      @(negedge clk);
      mon_en = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("in_reset");
      rst = '0;
      repeat (3) @(negedge clk);
      check_all_zero("after_reset");

      // Single add/sub/invalid requests on port 1.
      start(0, 4'd1, 32'h0000_0001, 32'h1FFF_FFFF, 2'd1, 32'h2000_0000, 4, 1'b1); drain("add_small");
      start(0, 4'd1, 32'h1FFF_FFFF, 32'h1FFF_FFFF, 2'd1, 32'h3FFF_FFFE, 4, 1'b1); drain("add_mid");
      start(0, 4'd1, 32'h0000_0000, 32'h0000_0000, 2'd1, 32'h0000_0000, 4, 1'b1); drain("add_zero");
      start(0, 4'd1, 32'hFFFF_FFFF, 32'h0000_0000, 2'd1, 32'hFFFF_FFFF, 4, 1'b1); drain("add_max");
      start(0, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'h0000_0000, 4, 1'b1); drain("add_ovf");
      start(0, 4'd2, 32'h0000_0003, 32'h0000_0005, 2'd2, 32'h0000_0000, 4, 1'b1); drain("sub_unf");
      start(0, 4'd2, 32'h0000_0005, 32'h0000_0003, 2'd1, 32'h0000_0002, 4, 1'b1); drain("sub_ok");
      start(0, 4'd3, 32'h0000_0005, 32'h0000_0003, 2'd2, 32'h0000_0000, 3, 1'b1); drain("cmd_bad");

      // Shifts on port 4.
      start(3, 4'd5, 32'h0000_0001, 32'h0000_0021, 2'd1, 32'h0000_0002, 4, 1'b1); drain("shl");
      start(3, 4'd6, 32'h8000_0000, 32'h0000_001F, 2'd1, 32'h0000_0001, 4, 1'b1); drain("shr");

      // All four ports add 1+N together: served 1,2,3,4 on consecutive cycles.
      for (int p = 0; p < 4; p++)
         start(p, 4'd1, 32'd1, 32'(p + 1), 2'd1, 32'(p + 2), 4 + p, 1'b1);
      drain("contention");

      // Add and shift on different ports in the same cycle respond together.
      start(0, 4'd1, 32'd2, 32'd3, 2'd1, 32'd5, 4, 1'b1);
      start(1, 4'd5, 32'd3, 32'd2, 2'd1, 32'd12, 4, 1'b1);
      drain("mixed");

      // A second command while port 2 is pending is ignored.
      start(1, 4'd1, 32'd10, 32'd20, 2'd1, 32'd30, 4, 1'b1);
      step();
      step();
      cmd_in[1]  = 4'd1;
      data_in[1] = 32'h99;
      drain("busy");

      // A new request may start on the edge that ends the response cycle.
      start(2, 4'd1, 32'd7, 32'd8, 2'd1, 32'd15, 4, 1'b1);
      repeat (4) step();
      start(2, 4'd1, 32'd1, 32'd1, 2'd1, 32'd2, 4, 1'b1);
      drain("back_to_back");

      // Reset between E2 and E4 drops the request: no response may appear.
      start(0, 4'd1, 32'd5, 32'd6, 2'd1, 32'd11, 4, 1'b0);
      step();
      step();
      rst[4] = 1'b1;
      step();
      step();
      check_all_zero("mid_reset");
      rst = '0;
      repeat (6) step();
      start(0, 4'd1, 32'd5, 32'd6, 2'd1, 32'd11, 4, 1'b1); drain("post_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
